// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer and its command front-end.
// Holds the opcode enum plus command/result/tracking bundles.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ADD  = 2'd0,
        SUB  = 2'd1,
        MULT = 2'd2,
        DIV  = 2'd3
    } opcode_e;

    localparam int TAG_W = 4;

    typedef struct packed {
        opcode_e            opcode;
        logic signed [7:0]  op1;
        logic signed [7:0]  op2;
    } alu_cmd_t;

    typedef struct packed {
        logic signed [8:0]  data;
        logic [TAG_W-1:0]   tag;
        logic               err;
    } alu_res_t;

    typedef struct packed {
        logic               issued;
        logic [TAG_W-1:0]   tag;
        logic               err;
    } alu_trk_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO, any depth >= 2; push while full is refused even
// if a pop happens in the same cycle. Head is presented on dout_o.
module alu_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= nxt(wptr_q);
            if (pop_ok)  rptr_q <= nxt(rptr_q);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// Command FIFO + credit-based issue into alu_seq, tagged result return.
// Define ALU_CMD_DIVZERO_CHK_EN to trap DIV by zero before the ALU.
module alu_cmd_queue
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  opcode_e                 in_opcode,
    input  logic signed [7:0]       in_op1,
    input  logic signed [7:0]       in_op2,
    output logic signed [7:0]       operand1,
    output logic signed [7:0]       operand2,
    output opcode_e                 opcode,
    input  logic signed [8:0]       alu_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [8:0]       res_data,
    output logic [TAG_W-1:0]        res_tag,
    output logic                    res_err
);

    localparam int RBUF_DEPTH = ALU_LAT + 1;
    localparam int CCW = $clog2(DEPTH + 1);
    localparam int RCW = $clog2(RBUF_DEPTH + 1);
    localparam int SW  = RCW + 1;

    alu_cmd_t          cmd_in, cmd_head;
    logic              cmd_full, cmd_empty;
    logic [CCW-1:0]    cmd_count;
    alu_res_t          rbuf_in, rbuf_head;
    logic              rbuf_full, rbuf_empty;
    logic [RCW-1:0]    rbuf_count;

    logic signed [7:0] op1_q, op1_d, op2_q, op2_d;
    opcode_e           opc_q, opc_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    alu_trk_t          trk_q [ALU_LAT+1];
    alu_trk_t          trk_d;
    logic [RCW-1:0]    inflight;
    logic              issue, div0_err, cap;

    assign in_ready = ~rst & ~cmd_full;
    assign cmd_in   = '{opcode: in_opcode, op1: in_op1, op2: in_op2};

    alu_cmd_fifo #(.W($bits(alu_cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid & in_ready),
        .pop_i   (issue),
        .din_i   (cmd_in),
        .dout_o  (cmd_head),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .count_o (cmd_count)
    );

`ifdef ALU_CMD_DIVZERO_CHK_EN
    assign div0_err = (cmd_head.opcode == DIV) && (cmd_head.op2 == 8'sd0);
`else
    assign div0_err = 1'b0;
`endif

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= ALU_LAT; i++) begin
            inflight = inflight + RCW'(trk_q[i].issued);
        end
    end

    // Every issued command must already own a result-buffer slot.
    assign issue = ~cmd_empty
                 & ((SW'(inflight) + SW'(rbuf_count)) < SW'(RBUF_DEPTH));

    always_comb begin
        op1_d = '0;
        op2_d = '0;
        opc_d = ADD;
        if (issue && !div0_err) begin
            op1_d = cmd_head.op1;
            op2_d = cmd_head.op2;
            opc_d = cmd_head.opcode;
        end
        trk_d = '{issued: issue, tag: tag_q, err: issue & div0_err};
        tag_d = issue ? tag_q + 1'b1 : tag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op1_q <= '0;
            op2_q <= '0;
            opc_q <= ADD;
            tag_q <= '0;
            for (int i = 0; i <= ALU_LAT; i++) trk_q[i] <= '0;
        end else begin
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            opc_q    <= opc_d;
            tag_q    <= tag_d;
            trk_q[0] <= trk_d;
            for (int i = 1; i <= ALU_LAT; i++) trk_q[i] <= trk_q[i-1];
        end
    end

    assign operand1 = op1_q;
    assign operand2 = op2_q;
    assign opcode   = opc_q;

    assign cap     = trk_q[ALU_LAT].issued;
    assign rbuf_in = '{data: trk_q[ALU_LAT].err ? 9'sd0 : alu_out,
                       tag:  trk_q[ALU_LAT].tag,
                       err:  trk_q[ALU_LAT].err};

    alu_cmd_fifo #(.W($bits(alu_res_t)), .DEPTH(RBUF_DEPTH)) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cap),
        .pop_i   (res_valid & res_ready),
        .din_i   (rbuf_in),
        .dout_o  (rbuf_head),
        .full_o  (rbuf_full),
        .empty_o (rbuf_empty),
        .count_o (rbuf_count)
    );

    // Storage is unreset, so the head is masked while the buffer is empty.
    assign res_valid = ~rbuf_empty;
    assign res_data  = rbuf_empty ? 9'sd0 : rbuf_head.data;
    assign res_tag   = rbuf_empty ? '0 : rbuf_head.tag;
    assign res_err   = ~rbuf_empty & rbuf_head.err;

    logic unused_ok;
    assign unused_ok = ^{cmd_count, rbuf_full};

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue with a registered ALU model.
// Honours ALU_CMD_DIVZERO_CHK_EN for the divide-by-zero expectations.
module tb_alu_cmd_queue;
    import alu_seq_pkg::*;

    localparam int DEPTH   = 8;
    localparam int ALU_LAT = 1;
    localparam int RBUF    = ALU_LAT + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    opcode_e           in_opcode = ADD;
    logic signed [7:0] in_op1 = '0;
    logic signed [7:0] in_op2 = '0;
    logic signed [7:0] operand1, operand2;
    opcode_e           opcode;
    logic signed [8:0] alu_out = '0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic signed [8:0] res_data;
    logic [3:0]        res_tag;
    logic              res_err;

    int         total = 0;
    int         bad = 0;
    int         div0_seen = 0;
    alu_res_t   exp_q[$];
    alu_res_t   got_q[$];
    logic [3:0] exp_tag = '0;

    always #5 clk = ~clk;

    alu_cmd_queue #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_op1    (in_op1),
        .in_op2    (in_op2),
        .operand1  (operand1),
        .operand2  (operand2),
        .opcode    (opcode),
        .alu_out   (alu_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .res_err   (res_err)
    );

    function automatic logic signed [8:0] golden(opcode_e o,
            logic signed [7:0] a, logic signed [7:0] b);
        logic signed [15:0] x, y, w;
        x = a;
        y = b;
        case (o)
            ADD:  w = x + y;
            SUB:  w = x - y;
            MULT: w = x * y;
            default: w = (y == 0) ? 16'sd0 : x / y;
        endcase
        return w[8:0];
    endfunction

    always @(posedge clk) alu_out <= golden(opcode, operand1, operand2);

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready)
            got_q.push_back('{data: res_data, tag: res_tag, err: res_err});
        if (!rst && opcode == DIV && operand2 == 8'sd0)
            div0_seen = div0_seen + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_tag = '0;
        exp_q.delete();
    endtask

    function automatic alu_res_t mk_exp(opcode_e o,
            logic signed [7:0] a, logic signed [7:0] b);
        alu_res_t e;
        e.data = golden(o, a, b);
        e.tag  = exp_tag;
        e.err  = 1'b0;
`ifdef ALU_CMD_DIVZERO_CHK_EN
        if (o == DIV && b == 8'sd0) begin
            e.data = '0;
            e.err  = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic push_cmd(input opcode_e o, input logic signed [7:0] a,
            input logic signed [7:0] b, output bit ok);
        in_valid  = 1'b1;
        in_opcode = o;
        in_op1    = a;
        in_op2    = b;
        ok = 1'b0;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                exp_q.push_back(mk_exp(o, a, b));
                exp_tag = exp_tag + 4'd1;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready);
        end
        total++;
        if ({res_valid, res_data, res_tag, res_err} !== '0) begin
            bad++;
            $display("FAIL rst_res got v=%b d=%0d t=%0d e=%b want all 0",
                     res_valid, res_data, res_tag, res_err);
        end
        total++;
        if (operand1 !== 8'sd0 || operand2 !== 8'sd0 || opcode !== ADD) begin
            bad++;
            $display("FAIL rst_alu_in got %0d %0d op=%0d want 0 0 ADD",
                     operand1, operand2, opcode);
        end
        step();
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        int base;
        do_reset(2);
        base = got_q.size();
        res_ready = 1'b1;
        push_cmd(ADD, 8'sd100, 8'sd27, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_accept got=0 want=1"); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (res_valid !== (k == 3)) begin
                bad++;
                $display("FAIL single_valid_cyc%0d got=%b want=%b",
                         k, res_valid, k == 3);
            end
            if (k == 1) begin
                total++;
                if (operand1 !== 8'sd100 || operand2 !== 8'sd27 || opcode !== ADD) begin
                    bad++;
                    $display("FAIL single_alu_in got %0d %0d op=%0d want 100 27 ADD",
                             operand1, operand2, opcode);
                end
            end
            if (k == 3) begin
                total++;
                if (res_data !== 9'sd127 || res_tag !== 4'd0) begin
                    bad++;
                    $display("FAIL single_res got d=%0d t=%0d want d=127 t=0",
                             res_data, res_tag);
                end
            end
        end
        step();
        total++;
        if (got_q.size() - base != 1) begin
            bad++;
            $display("FAIL single_count got=%0d want=1", got_q.size() - base);
        end
    endtask

    task automatic test_back_to_back();
        opcode_e           o_t[20];
        logic signed [7:0] a_t[20], b_t[20];
        bit ok;
        int base, acc;
        o_t[0] = SUB;  a_t[0] = -8'sd128; b_t[0] = 8'sd1;
        o_t[1] = MULT; a_t[1] = -8'sd8;   b_t[1] = 8'sd16;
        o_t[2] = DIV;  a_t[2] = 8'sd7;    b_t[2] = -8'sd2;
        o_t[3] = ADD;  a_t[3] = 8'sd127;  b_t[3] = 8'sd127;
        o_t[4] = ADD;  a_t[4] = -8'sd128; b_t[4] = -8'sd128;
        o_t[5] = MULT; a_t[5] = 8'sd127;  b_t[5] = 8'sd127;
        o_t[6] = DIV;  a_t[6] = -8'sd128; b_t[6] = -8'sd1;
        for (int i = 7; i < 20; i++) begin
            o_t[i] = opcode_e'($urandom_range(0, 3));
            a_t[i] = 8'($urandom);
            b_t[i] = 8'($urandom);
            if (o_t[i] == DIV && b_t[i] == 8'sd0) b_t[i] = 8'sd3;
        end
        do_reset(2);
        base = got_q.size();
        res_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            push_cmd(o_t[i], a_t[i], b_t[i], ok);
            if (ok) acc++;
        end
        total++;
        if (acc != 20) begin
            bad++; $display("FAIL b2b_accepted got=%0d want=20", acc);
        end
        for (int k = 0; k < 300 && got_q.size() - base < exp_q.size(); k++)
            @(negedge clk);
        total++;
        if (got_q.size() - base != exp_q.size()) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=%0d",
                     got_q.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (base + i < got_q.size()) begin
                total++;
                if (got_q[base+i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL b2b_res[%0d] got d=%0d t=%0d e=%b want d=%0d t=%0d e=%b",
                             i, $signed(got_q[base+i].data), got_q[base+i].tag,
                             got_q[base+i].err, $signed(exp_q[i].data),
                             exp_q[i].tag, exp_q[i].err);
                end
            end
        end
        total++;
        if (exp_q.size() == 20 && (exp_q[19].tag !== 4'd3 || exp_q[16].tag !== 4'd0)) begin
            bad++;
            $display("FAIL b2b_tagwrap got t16=%0d t19=%0d want 0 3",
                     exp_q[16].tag, exp_q[19].tag);
        end
        step();
    endtask

    task automatic test_backpressure();
        int base, acc;
        opcode_e o;
        logic signed [7:0] a, b;
        do_reset(2);
        base = got_q.size();
        res_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 30; c++) begin
            o = opcode_e'($urandom_range(0, 3));
            a = 8'($urandom);
            b = 8'($urandom);
            if (o == DIV && b == 8'sd0) b = -8'sd5;
            in_valid = 1'b1; in_opcode = o; in_op1 = a; in_op2 = b;
            @(negedge clk);
            if (in_ready) begin
                acc++;
                exp_q.push_back(mk_exp(o, a, b));
                exp_tag = exp_tag + 4'd1;
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (acc != DEPTH + RBUF) begin
            bad++; $display("FAIL bp_accepted got=%0d want=%0d", acc, DEPTH + RBUF);
        end
        total++;
        if (in_ready !== 1'b0 || res_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_stall got in_ready=%b res_valid=%b want 0 1",
                     in_ready, res_valid);
        end
        total++;
        if (got_q.size() != base) begin
            bad++; $display("FAIL bp_leak got=%0d want=0", got_q.size() - base);
        end
        step();
        res_ready = 1'b1;
        for (int k = 0; k < 300 && got_q.size() - base < exp_q.size(); k++)
            @(negedge clk);
        total++;
        if (got_q.size() - base != exp_q.size()) begin
            bad++;
            $display("FAIL bp_count got=%0d want=%0d",
                     got_q.size() - base, exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (base + i < got_q.size()) begin
                total++;
                if (got_q[base+i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL bp_res[%0d] got d=%0d t=%0d want d=%0d t=%0d",
                             i, $signed(got_q[base+i].data), got_q[base+i].tag,
                             $signed(exp_q[i].data), exp_q[i].tag);
                end
            end
        end
        step();
    endtask

    task automatic test_divzero();
        bit ok;
        int base, d0;
        do_reset(2);
        base = got_q.size();
        d0 = div0_seen;
        res_ready = 1'b1;
        push_cmd(DIV, 8'sd5, 8'sd0, ok);
        push_cmd(ADD, 8'sd1, 8'sd2, ok);
        for (int k = 0; k < 50 && got_q.size() - base < 2; k++)
            @(negedge clk);
        total++;
        if (got_q.size() - base != 2) begin
            bad++; $display("FAIL dz_count got=%0d want=2", got_q.size() - base);
        end else begin
            total++;
`ifdef ALU_CMD_DIVZERO_CHK_EN
            if (got_q[base].err !== 1'b1 || got_q[base].data !== 9'sd0) begin
                bad++;
                $display("FAIL dz_res got d=%0d e=%b want d=0 e=1",
                         $signed(got_q[base].data), got_q[base].err);
            end
`else
            if (got_q[base].err !== 1'b0) begin
                bad++;
                $display("FAIL dz_res got e=%b want e=0", got_q[base].err);
            end
`endif
            total++;
            if (got_q[base+1] !== exp_q[1] || got_q[base+1].tag !== 4'd1) begin
                bad++;
                $display("FAIL dz_next got d=%0d t=%0d want d=3 t=1",
                         $signed(got_q[base+1].data), got_q[base+1].tag);
            end
        end
        total++;
`ifdef ALU_CMD_DIVZERO_CHK_EN
        if (div0_seen != d0) begin
            bad++; $display("FAIL dz_alu_saw got=%0d want=0", div0_seen - d0);
        end
`else
        if (div0_seen == d0) begin
            bad++; $display("FAIL dz_alu_saw got=0 want>0");
        end
`endif
        step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int base, vcnt;
        do_reset(2);
        res_ready = 1'b0;
        for (int i = 0; i < 7; i++)
            push_cmd(MULT, 8'(i + 2), 8'sd3, ok);
        repeat (3) step();
        do_reset(2);
        res_ready = 1'b1;
        base = got_q.size();
        vcnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (res_valid) vcnt++;
        end
        total++;
        if (vcnt != 0) begin
            bad++; $display("FAIL midrst_stale got=%0d want=0", vcnt);
        end
        step();
        push_cmd(ADD, 8'sd3, 8'sd4, ok);
        for (int k = 0; k < 50 && got_q.size() - base < 1; k++)
            @(negedge clk);
        total++;
        if (got_q.size() - base != 1) begin
            bad++; $display("FAIL midrst_count got=%0d want=1", got_q.size() - base);
        end else begin
            total++;
            if (got_q[base].tag !== 4'd0 || got_q[base].data !== 9'sd7) begin
                bad++;
                $display("FAIL midrst_res got d=%0d t=%0d want d=7 t=0",
                         $signed(got_q[base].data), got_q[base].tag);
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_divzero();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
